// File: rtl/conv_fft_out_writer.sv
// Output writer behind the FFT conv layer: buffers 512-bit lines in a small FIFO and drains them as addressed writes.
// Optional CONV_FFT_OUT_WRITER_CHECKSUM_EN adds an XOR checksum port over all accepted write payloads.
module conv_fft_out_writer #(
    parameter int DEPTH        = 8,
    parameter int AFULL_MARGIN = 2,
    parameter int ADDR_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [31:0]           ctx_length,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic                  in_valid,
    input  logic [511:0]          in_data,
    output logic                  fifo_full,
    output logic                  wr_valid,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [511:0]          wr_data,
    input  logic                  wr_ready,
    output logic                  done,
`ifdef CONV_FFT_OUT_WRITER_CHECKSUM_EN
    output logic [31:0]           checksum,
`endif
    output logic                  err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_LVL  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_LVL = CW'(DEPTH - AFULL_MARGIN);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [31:0]           len_q, len_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [31:0]           in_count_q, in_count_d;
    logic [31:0]           out_count_q, out_count_d;
    logic [31:0]           out_index_q, out_index_d;
    logic [PW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  fifo_full_q, fifo_full_d;
    logic                  wr_valid_q, wr_valid_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [511:0]          wr_data_q, wr_data_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [511:0]          mem_q [DEPTH];

    logic push_s, load_s, hs_s, start_ok_s;

`ifdef CONV_FFT_OUT_WRITER_CHECKSUM_EN
    logic [31:0] checksum_q, checksum_d;

    function automatic logic [31:0] fold_words(input logic [511:0] d);
        logic [31:0] acc;
        acc = 32'd0;
        for (int w = 0; w < 16; w++) begin
            acc = acc ^ d[w*32 +: 32];
        end
        return acc;
    endfunction
`endif

    // Handshake qualifiers: a push needs RUN and a free slot; the output register reloads whenever it is empty or being accepted.
    always_comb begin
        start_ok_s = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
        push_s     = in_valid && (state_q == ST_RUN) && (count_q != FULL_LVL);
        hs_s       = wr_valid_q && wr_ready;
        load_s     = (!wr_valid_q || wr_ready) && (count_q != {CW{1'b0}});
    end

    // Next-state logic for the job FSM, FIFO bookkeeping and the output register.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        base_d      = base_q;
        in_count_d  = in_count_q + 32'(push_s);
        out_count_d = out_count_q + 32'(hs_s);
        out_index_d = out_index_q + 32'(load_s);
        err_d       = err_q | (in_valid & ~push_s);
        wptr_d      = push_s ? (wptr_q + PW'(1)) : wptr_q;
        rptr_d      = load_s ? (rptr_q + PW'(1)) : rptr_q;
        count_d     = count_q + CW'(push_s) - CW'(load_s);
        fifo_full_d = (count_d >= AFULL_LVL);
        wr_valid_d  = wr_valid_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;

        if (load_s) begin
            wr_valid_d = 1'b1;
            wr_addr_d  = base_q + ADDR_WIDTH'(out_index_q);
            wr_data_d  = mem_q[rptr_q];
        end else if (hs_s) begin
            wr_valid_d = 1'b0;
        end else begin
            wr_valid_d = wr_valid_q;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_ok_s) begin
                    len_d       = ctx_length;
                    base_d      = base_addr;
                    in_count_d  = 32'd0;
                    out_count_d = 32'd0;
                    out_index_d = 32'd0;
                    err_d       = 1'b0;
                    state_d     = (ctx_length == 32'd0) ? ST_DONE : ST_RUN;
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUN: begin
                if (in_count_d == len_q) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (out_count_d == len_q) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        done_d = (state_d == ST_DONE);

`ifdef CONV_FFT_OUT_WRITER_CHECKSUM_EN
        if (start_ok_s) begin
            checksum_d = 32'd0;
        end else if (hs_s) begin
            checksum_d = checksum_q ^ fold_words(wr_data_q);
        end else begin
            checksum_d = checksum_q;
        end
`endif
    end

    // Line storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wptr_q] <= in_data;
        end
    end

    // State, counters, pointers and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            len_q       <= 32'd0;
            base_q      <= {ADDR_WIDTH{1'b0}};
            in_count_q  <= 32'd0;
            out_count_q <= 32'd0;
            out_index_q <= 32'd0;
            wptr_q      <= {PW{1'b0}};
            rptr_q      <= {PW{1'b0}};
            count_q     <= {CW{1'b0}};
            fifo_full_q <= 1'b0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= {ADDR_WIDTH{1'b0}};
            wr_data_q   <= 512'd0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef CONV_FFT_OUT_WRITER_CHECKSUM_EN
            checksum_q  <= 32'd0;
`endif
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            base_q      <= base_d;
            in_count_q  <= in_count_d;
            out_count_q <= out_count_d;
            out_index_q <= out_index_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            fifo_full_q <= fifo_full_d;
            wr_valid_q  <= wr_valid_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            done_q      <= done_d;
            err_q       <= err_d;
`ifdef CONV_FFT_OUT_WRITER_CHECKSUM_EN
            checksum_q  <= checksum_d;
`endif
        end
    end

    assign fifo_full = fifo_full_q;
    assign wr_valid  = wr_valid_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign done      = done_q;
    assign err       = err_q;
`ifdef CONV_FFT_OUT_WRITER_CHECKSUM_EN
    assign checksum  = checksum_q;
`endif

endmodule

// File: tb/tb_conv_fft_out_writer.sv
// Directed bench for conv_fft_out_writer: ordering, throttling, overflow, zero-length jobs and async reset.
module tb_conv_fft_out_writer;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [31:0]  ctx_length;
    logic [31:0]  base_addr;
    logic         in_valid;
    logic [511:0] in_data;
    logic         fifo_full;
    logic         wr_valid;
    logic [31:0]  wr_addr;
    logic [511:0] wr_data;
    logic         wr_ready;
    logic         done;
    logic         err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0]  hs_addr [$];
    logic [511:0] hs_data [$];
    logic [15:0]  exp_tags [$];

    always #5 clk = ~clk;

    conv_fft_out_writer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .ctx_length (ctx_length),
        .base_addr  (base_addr),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .fifo_full  (fifo_full),
        .wr_valid   (wr_valid),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .done       (done),
        .err        (err)
    );

    // Record every accepted write request, sampled mid-cycle.
    always @(negedge clk) begin
        if (reset_n && wr_valid && wr_ready) begin
            hs_addr.push_back(wr_addr);
            hs_data.push_back(wr_data);
        end
    end

    function automatic logic [511:0] line_data(input logic [15:0] tag);
        logic [511:0] d;
        for (int w = 0; w < 16; w++) begin
            d[w*32 +: 32] = {tag, 16'(w)};
        end
        return d;
    endfunction

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] len, input logic [31:0] base);
        hs_addr.delete();
        hs_data.delete();
        exp_tags.delete();
        start      = 1'b1;
        ctx_length = len;
        base_addr  = base;
        tick();
        start = 1'b0;
    endtask

    task automatic push_line(input logic [15:0] tag);
        in_valid = 1'b1;
        in_data  = line_data(tag);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_hs(input int n);
        int cyc = 0;
        while (hs_addr.size() < n && cyc < 200) begin
            tick();
            cyc++;
        end
        check_eq("hs_count", 512'(hs_addr.size()), 512'(n));
    endtask

    task automatic check_writes(input logic [31:0] base);
        check_eq("n_writes", 512'(hs_addr.size()), 512'(exp_tags.size()));
        for (int i = 0; i < exp_tags.size() && i < hs_addr.size(); i++) begin
            check_eq("wr_addr", 512'(hs_addr[i]), 512'(base + 32'(i)));
            check_eq("wr_data", hs_data[i], line_data(exp_tags[i]));
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_fifo_full"}, 512'(fifo_full), 512'd0);
        check_eq({tag, "_wr_valid"}, 512'(wr_valid), 512'd0);
        check_eq({tag, "_wr_addr"}, 512'(wr_addr), 512'd0);
        check_eq({tag, "_wr_data"}, wr_data, 512'd0);
        check_eq({tag, "_done"}, 512'(done), 512'd0);
        check_eq({tag, "_err"}, 512'(err), 512'd0);
    endtask

    initial begin
        int pushes;
        int first_full;
        logic ff_prev;
        logic ff_now;
        logic exp_ff;

        reset_n    = 1'b0;
        start      = 1'b0;
        ctx_length = 32'd0;
        base_addr  = 32'd0;
        in_valid   = 1'b0;
        in_data    = 512'd0;
        wr_ready   = 1'b0;
        repeat (2) tick();
        check_outputs_zero("reset");
        reset_n = 1'b1;
        tick();

        // Zero-length job completes on the start edge, never issues a write.
        do_start(32'd0, 32'h80);
        check_eq("zero_done", 512'(done), 512'd1);
        check_eq("zero_wr_valid", 512'(wr_valid), 512'd0);
        tick();
        check_eq("zero_wr_valid2", 512'(wr_valid), 512'd0);

        // Four lines, sink always ready.
        wr_ready = 1'b1;
        do_start(32'd4, 32'h100);
        check_eq("basic_done_cleared", 512'(done), 512'd0);
        for (int i = 0; i < 4; i++) begin
            push_line(16'h0100 + 16'(i));
            exp_tags.push_back(16'h0100 + 16'(i));
        end
        check_eq("basic_err", 512'(err), 512'd0);
        wait_hs(3);
        check_eq("basic_done_early", 512'(done), 512'd0);
        wait_hs(4);
        check_eq("basic_done", 512'(done), 512'd1);
        check_writes(32'h100);

        // Stalled sink, producer honouring fifo_full with one cycle of lag.
        wr_ready = 1'b0;
        do_start(32'd8, 32'h200);
        pushes = 0;
        first_full = -1;
        ff_prev = 1'b0;
        for (int c = 0; c < 40 && pushes < 8; c++) begin
            ff_now = fifo_full;
            if (ff_now && first_full < 0) first_full = pushes;
            in_valid = !ff_prev;
            in_data  = line_data(16'h0200 + 16'(pushes));
            ff_prev  = ff_now;
            tick();
            if (in_valid) pushes++;
        end
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) exp_tags.push_back(16'h0200 + 16'(i));
        check_eq("stall_full_rise_pushes", 512'(first_full), 512'd7);
        check_eq("stall_pushes", 512'(pushes), 512'd8);
        check_eq("stall_err", 512'(err), 512'd0);
        check_eq("stall_fifo_full", 512'(fifo_full), 512'd1);
        check_eq("stall_wr_valid", 512'(wr_valid), 512'd1);
        repeat (3) tick();
        check_eq("stall_addr_hold", 512'(wr_addr), 512'h200);
        check_eq("stall_data_hold", wr_data, line_data(16'h0200));
        wr_ready = 1'b1;
        wait_hs(8);
        check_eq("stall_done", 512'(done), 512'd1);
        check_writes(32'h200);

        // Overflow: ninth buffered line fills the FIFO, tenth is dropped.
        wr_ready = 1'b0;
        do_start(32'd10, 32'h300);
        for (int i = 0; i < 9; i++) begin
            push_line(16'h0300 + 16'(i));
            exp_tags.push_back(16'h0300 + 16'(i));
        end
        check_eq("ovf_err_before", 512'(err), 512'd0);
        check_eq("ovf_fifo_full", 512'(fifo_full), 512'd1);
        push_line(16'h0309);
        check_eq("ovf_err", 512'(err), 512'd1);
        wr_ready = 1'b1;
        repeat (3) tick();
        push_line(16'h030A);
        exp_tags.push_back(16'h030A);
        wait_hs(10);
        check_eq("ovf_done", 512'(done), 512'd1);
        check_eq("ovf_err_sticky", 512'(err), 512'd1);
        check_writes(32'h300);

        // Sink ready toggling while the producer streams 16 lines.
        do_start(32'd16, 32'h400);
        pushes = 0;
        ff_prev = 1'b0;
        for (int c = 0; c < 200 && hs_addr.size() < 16; c++) begin
            ff_now = fifo_full;
            exp_ff = (pushes - hs_addr.size() - int'(wr_valid)) >= 6;
            check_eq("toggle_fifo_full", 512'(ff_now), 512'(exp_ff));
            in_valid = (pushes < 16) && !ff_prev;
            in_data  = line_data(16'h0400 + 16'(pushes));
            wr_ready = (c % 2) == 0;
            ff_prev  = ff_now;
            tick();
            if (in_valid) pushes++;
        end
        in_valid = 1'b0;
        wr_ready = 1'b1;
        for (int i = 0; i < 16; i++) exp_tags.push_back(16'h0400 + 16'(i));
        check_eq("toggle_err", 512'(err), 512'd0);
        check_eq("toggle_done", 512'(done), 512'd1);
        check_writes(32'h400);

        // Asynchronous reset in DRAIN with lines still buffered.
        wr_ready = 1'b0;
        do_start(32'd3, 32'h500);
        for (int i = 0; i < 3; i++) push_line(16'h0500 + 16'(i));
        check_eq("rst_pre_wr_valid", 512'(wr_valid), 512'd1);
        check_eq("rst_pre_wr_addr", 512'(wr_addr), 512'h500);
        #2;
        reset_n = 1'b0;
        #1;
        check_outputs_zero("async_rst");
        tick();
        reset_n = 1'b1;
        tick();
        wr_ready = 1'b1;
        do_start(32'd2, 32'h600);
        for (int i = 0; i < 2; i++) begin
            push_line(16'h0600 + 16'(i));
            exp_tags.push_back(16'h0600 + 16'(i));
        end
        wait_hs(2);
        check_eq("post_rst_done", 512'(done), 512'd1);
        check_eq("post_rst_err", 512'(err), 512'd0);
        check_writes(32'h600);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
